lms_sequencer: RTL

Control FSM for the adaptive LMS filter datapath. It walks the input-sample memory one address at a time. For each sample it runs these phases in order: fetch, delay-line shift, FIR multiply-accumulate over all taps, error compute, weight update over all taps, and output handshake. It drives only strobes, addresses and tap indices; the sample memory, MAC, error and weight-update datapaths are separate blocks.

---
 rtl/lms_sequencer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/lms_sequencer.sv
// lms_sequencer: control FSM for the adaptive LMS filter datapath.
// Walks the sample memory one address at a time and, for each sample,
// sequences fetch, delay-line shift, FIR MAC over all taps, error latch,
// weight update over all taps and the output handshake. Every output is a
// register updated alongside the state, so no input reaches an output
// combinationally.
module lms_sequencer #(
  parameter int N_SAMPLES = 20,
  parameter int TAPS      = 4,
  parameter int AW        = $clog2(N_SAMPLES),
  parameter int TW        = (TAPS > 1) ? $clog2(TAPS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          y_ready,
  output logic [AW-1:0] sample_addr,
  output logic          sample_rd,
  output logic          shift_en,
  output logic          mac_clr,
  output logic          mac_en,
  output logic [TW-1:0] tap_idx,
  output logic          err_en,
  output logic          upd_en,
  output logic          y_valid,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_SHIFT  = 3'd2,
    S_FILTER = 3'd3,
    S_ERROR  = 3'd4,
    S_UPDATE = 3'd5,
    S_OUTPUT = 3'd6,
    S_DONE   = 3'd7
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(N_SAMPLES - 1);
  localparam logic [TW-1:0] LAST_TAP  = TW'(TAPS - 1);

  state_t        r_state;
  logic [AW-1:0] r_addr;
  logic [TW-1:0] r_tap;
  logic          r_sample_rd;
  logic          r_shift_en;
  logic          r_mac_clr;
  logic          r_mac_en;
  logic          r_err_en;
  logic          r_upd_en;
  logic          r_y_valid;
  logic          r_busy;
  logic          r_done;

  // State, counters and registered outputs. Each transition loads the
  // outputs that belong to the state being entered; single-cycle strobes
  // default low every cycle, busy/done/addr hold unless explicitly changed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_tap       <= '0;
      r_sample_rd <= 1'b0;
      r_shift_en  <= 1'b0;
      r_mac_clr   <= 1'b0;
      r_mac_en    <= 1'b0;
      r_err_en    <= 1'b0;
      r_upd_en    <= 1'b0;
      r_y_valid   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_sample_rd <= 1'b0;
      r_shift_en  <= 1'b0;
      r_mac_clr   <= 1'b0;
      r_mac_en    <= 1'b0;
      r_err_en    <= 1'b0;
      r_upd_en    <= 1'b0;
      r_y_valid   <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state     <= S_FETCH;
            r_addr      <= '0;
            r_tap       <= '0;
            r_sample_rd <= 1'b1;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
          end else begin
            r_state <= r_state;
          end
        end
        S_FETCH: begin
          r_state    <= S_SHIFT;
          r_tap      <= '0;
          r_shift_en <= 1'b1;
          r_mac_clr  <= 1'b1;
        end
        S_SHIFT: begin
          r_state  <= S_FILTER;
          r_tap    <= '0;
          r_mac_en <= 1'b1;
        end
        S_FILTER: begin
          if (r_tap == LAST_TAP) begin
            r_state  <= S_ERROR;
            r_tap    <= '0;
            r_err_en <= 1'b1;
          end else begin
            r_tap    <= r_tap + TW'(1);
            r_mac_en <= 1'b1;
          end
        end
        S_ERROR: begin
          r_state  <= S_UPDATE;
          r_tap    <= '0;
          r_upd_en <= 1'b1;
        end
        S_UPDATE: begin
          if (r_tap == LAST_TAP) begin
            r_state   <= S_OUTPUT;
            r_tap     <= '0;
            r_y_valid <= 1'b1;
          end else begin
            r_tap    <= r_tap + TW'(1);
            r_upd_en <= 1'b1;
          end
        end
        S_OUTPUT: begin
          if (!y_ready) begin
            r_y_valid <= 1'b1;
          end else if (r_addr == LAST_ADDR) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state     <= S_FETCH;
            r_addr      <= r_addr + AW'(1);
            r_sample_rd <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_addr  <= '0;
          r_tap   <= '0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign sample_addr = r_addr;
  assign tap_idx     = r_tap;
  assign sample_rd   = r_sample_rd;
  assign shift_en    = r_shift_en;
  assign mac_clr     = r_mac_clr;
  assign mac_en      = r_mac_en;
  assign err_en      = r_err_en;
  assign upd_en      = r_upd_en;
  assign y_valid     = r_y_valid;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule
